// File: rtl/ruler_ascii_formatter_if.sv
// ruler_ascii_formatter_if
//   Byte stream from the ruler formatter to the UART transmitter.
//   tx_data  : ASCII byte offered downstream
//   tx_valid : tx_data is valid
//   tx_ready : downstream accepts; transfer on tx_valid && tx_ready
//   master   : formatter side (drives data/valid)
//   slave    : transmitter side (drives ready)
interface ruler_ascii_formatter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/ruler_ascii_formatter.sv
// ruler_ascii_formatter
//   Converts an N-row bitmap of mark positions into an ASCII report: one
//   line per row listing the set positions in decimal, separated by spaces,
//   terminated by "\n". A request with done=0 produces "-\n".
//   Optional feature macro FMT_ROW_LABEL_EN: prefix each row line with
//   "<row>: ".
// Ports
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   start  : one-cycle request to format ruler/done
//   ruler  : bitmap, row r mark j at bit (M+1)*r + j
//   done   : result-valid flag
//   tx     : byte stream (master modport of ruler_ascii_formatter_if)
//   busy   : message in progress
module ruler_ascii_formatter #(
  parameter int N  = 14,
  parameter int M  = 140,
  parameter int PW = $clog2(M + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [N*(M+1)-1:0]    ruler,
  input  logic                  done,
  ruler_ascii_formatter_if.master tx,
  output logic                  busy
);

`ifdef FMT_ROW_LABEL_EN
  localparam bit LABEL_EN = 1'b1;
`else
  localparam bit LABEL_EN = 1'b0;
`endif

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int VW = 10;  // holds any value up to 999

  typedef enum logic [2:0] {IDLE, SCAN, CONV, EMIT, EOL, DONE} state_t;

  // EMIT sub-steps: 0 separator, 1 hundreds, 2 tens, 3 units, 4 ':', 5 ' '
  state_t             r_state, w_state_nxt;
  logic [N*(M+1)-1:0] r_ruler, w_ruler_nxt;
  logic [RW-1:0]      r_row,   w_row_nxt;
  logic [PW-1:0]      r_pos,   w_pos_nxt;
  logic [VW-1:0]      r_val,   w_val_nxt;
  logic [3:0]         r_hund,  w_hund_nxt;
  logic [3:0]         r_tens,  w_tens_nxt;
  logic [2:0]         r_phase, w_phase_nxt;
  logic               r_first, w_first_nxt;
  logic               r_label, w_label_nxt;
  logic               r_busy,  w_busy_nxt;
  logic               r_last,  w_last_nxt;
  logic [7:0]         r_tx_data,  w_tx_data_nxt;
  logic               r_tx_valid, w_tx_valid_nxt;

  logic [M:0]         w_row_bits;
  logic               w_bit;
  logic               w_xfer;
  logic               w_free;
  logic               w_load;
  logic [7:0]         w_byte;

  assign w_row_bits  = r_ruler[int'(r_row)*(M+1) +: (M+1)];
  assign w_bit       = w_row_bits[r_pos];
  assign w_xfer      = r_tx_valid && tx.tx_ready;
  // Output slot can take a new byte when empty or being drained this cycle.
  assign w_free      = !r_tx_valid || tx.tx_ready;

  assign tx.tx_data  = r_tx_data;
  assign tx.tx_valid = r_tx_valid;
  assign busy        = r_busy;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_ruler    <= '0;
      r_row      <= '0;
      r_pos      <= '0;
      r_val      <= '0;
      r_hund     <= '0;
      r_tens     <= '0;
      r_phase    <= '0;
      r_first    <= 1'b0;
      r_label    <= 1'b0;
      r_busy     <= 1'b0;
      r_last     <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ruler    <= w_ruler_nxt;
      r_row      <= w_row_nxt;
      r_pos      <= w_pos_nxt;
      r_val      <= w_val_nxt;
      r_hund     <= w_hund_nxt;
      r_tens     <= w_tens_nxt;
      r_phase    <= w_phase_nxt;
      r_first    <= w_first_nxt;
      r_label    <= w_label_nxt;
      r_busy     <= w_busy_nxt;
      r_last     <= w_last_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ruler_nxt    = r_ruler;
    w_row_nxt      = r_row;
    w_pos_nxt      = r_pos;
    w_val_nxt      = r_val;
    w_hund_nxt     = r_hund;
    w_tens_nxt     = r_tens;
    w_phase_nxt    = r_phase;
    w_first_nxt    = r_first;
    w_label_nxt    = r_label;
    w_busy_nxt     = r_busy;
    w_last_nxt     = r_last;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    w_load         = 1'b0;
    w_byte         = r_tx_data;

    // The FSM returns to IDLE once the final "\n" is queued; busy is held
    // until that byte actually leaves.
    if (w_xfer) begin
      w_tx_valid_nxt = 1'b0;
      if (r_last) begin
        w_busy_nxt = 1'b0;
        w_last_nxt = 1'b0;
      end
    end

    unique case (r_state)
      IDLE: begin
        if (start && !r_busy && !r_tx_valid) begin
          w_ruler_nxt = ruler;
          w_row_nxt   = '0;
          w_pos_nxt   = '0;
          w_phase_nxt = '0;
          w_first_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
          if (!done) begin
            w_state_nxt = DONE;
          end else if (LABEL_EN) begin
            w_val_nxt   = '0;
            w_hund_nxt  = '0;
            w_tens_nxt  = '0;
            w_label_nxt = 1'b1;
            w_state_nxt = CONV;
          end else begin
            w_state_nxt = SCAN;
          end
        end
      end

      SCAN: begin
        if (w_bit) begin
          w_val_nxt   = VW'(r_pos);
          w_hund_nxt  = '0;
          w_tens_nxt  = '0;
          w_label_nxt = 1'b0;
          w_state_nxt = CONV;
        end else if (r_pos == PW'(M)) begin
          w_state_nxt = EOL;
        end else begin
          w_pos_nxt = r_pos + 1'b1;
        end
      end

      CONV: begin
        if (r_val >= VW'(100)) begin
          w_val_nxt  = r_val - VW'(100);
          w_hund_nxt = r_hund + 1'b1;
        end else if (r_val >= VW'(10)) begin
          w_val_nxt  = r_val - VW'(10);
          w_tens_nxt = r_tens + 1'b1;
        end else begin
          w_phase_nxt = r_first ? 3'd1 : 3'd0;
          w_state_nxt = EMIT;
        end
      end

      EMIT: begin
        unique case (r_phase)
          3'd0: if (w_free) begin
            w_load = 1'b1; w_byte = 8'h20; w_phase_nxt = 3'd1;
          end
          3'd1: begin
            if (r_hund == '0) begin
              w_phase_nxt = 3'd2;
            end else if (w_free) begin
              w_load = 1'b1; w_byte = 8'h30 + {4'h0, r_hund}; w_phase_nxt = 3'd2;
            end
          end
          3'd2: begin
            if (r_hund == '0 && r_tens == '0) begin
              w_phase_nxt = 3'd3;
            end else if (w_free) begin
              w_load = 1'b1; w_byte = 8'h30 + {4'h0, r_tens}; w_phase_nxt = 3'd3;
            end
          end
          3'd3: if (w_free) begin
            w_load = 1'b1;
            w_byte = 8'h30 + {4'h0, r_val[3:0]};
            if (r_label) begin
              w_phase_nxt = 3'd4;
            end else begin
              w_first_nxt = 1'b0;
              if (r_pos == PW'(M)) begin
                w_state_nxt = EOL;
              end else begin
                w_pos_nxt   = r_pos + 1'b1;
                w_state_nxt = SCAN;
              end
            end
          end
          3'd4: if (w_free) begin
            w_load = 1'b1; w_byte = 8'h3A; w_phase_nxt = 3'd5;
          end
          default: if (w_free) begin
            // Label done; scanning of the row starts at position 0.
            w_load = 1'b1; w_byte = 8'h20; w_state_nxt = SCAN;
          end
        endcase
      end

      EOL: begin
        if (w_free) begin
          w_load = 1'b1;
          w_byte = 8'h0A;
          if (r_row != RW'(N - 1)) begin
            w_row_nxt   = r_row + 1'b1;
            w_pos_nxt   = '0;
            w_first_nxt = 1'b1;
            if (LABEL_EN) begin
              w_val_nxt   = VW'(r_row) + VW'(1);
              w_hund_nxt  = '0;
              w_tens_nxt  = '0;
              w_label_nxt = 1'b1;
              w_state_nxt = CONV;
            end else begin
              w_state_nxt = SCAN;
            end
          end else begin
            w_last_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end

      default: begin  // DONE: "-\n"
        if (w_free) begin
          w_load = 1'b1;
          if (r_phase == 3'd0) begin
            w_byte      = 8'h2D;
            w_phase_nxt = 3'd1;
          end else begin
            w_byte      = 8'h0A;
            w_last_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
    endcase

    if (w_load) begin
      w_tx_data_nxt  = w_byte;
      w_tx_valid_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_ruler_ascii_formatter.sv
// tb_ruler_ascii_formatter
//   Directed bench for ruler_ascii_formatter. DUT A: N=2, M=20.
//   DUT B: N=1, M=140. Honours FMT_ROW_LABEL_EN for expected strings.
module tb_ruler_ascii_formatter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic         start_a = 1'b0, done_a = 1'b0, busy_a;
  logic [41:0]  ruler_a = '0;
  logic         start_b = 1'b0, done_b = 1'b0, busy_b;
  logic [140:0] ruler_b = '0;

  ruler_ascii_formatter_if ifa();
  ruler_ascii_formatter_if ifb();

  ruler_ascii_formatter #(.N(2), .M(20)) dut_a (
    .clk(clk), .resetn(resetn), .start(start_a), .ruler(ruler_a),
    .done(done_a), .tx(ifa), .busy(busy_a));

  ruler_ascii_formatter #(.N(1), .M(140)) dut_b (
    .clk(clk), .resetn(resetn), .start(start_b), .ruler(ruler_b),
    .done(done_b), .tx(ifb), .busy(busy_b));

  int n_tests = 0;
  int n_fail  = 0;

`ifdef FMT_ROW_LABEL_EN
  string exp_case1 = "0: 0 3 17\n1: 20\n";
  string exp_empty = "0: \n1: 5\n";
  string exp_big   = "0: 0 99 100 140\n";
`else
  string exp_case1 = "0 3 17\n20\n";
  string exp_empty = "\n5\n";
  string exp_big   = "0 99 100 140\n";
`endif

  function automatic string to_hex(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) begin
      byte b = s[i];
      r = {r, $sformatf("%02h ", b)};
    end
    return r;
  endfunction

  function automatic logic [41:0] case1_bits();
    logic [41:0] v = '0;
    v[0] = 1'b1; v[3] = 1'b1; v[17] = 1'b1; v[21+20] = 1'b1;
    return v;
  endfunction

  task automatic pulse_a();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
  endtask

  // Collects nbytes transfers from DUT sel; reports stall instability,
  // busy timing errors around the final transfer, and a cycle-budget expiry.
  task automatic capture(input int sel, input int nbytes, input bit stall,
                         output string got, output int stab_err,
                         output int busy_err, output bit timeout);
    int cyc = 0;
    bit pv = 1'b0, pr = 1'b1, v, r, b;
    logic [7:0] pd = '0, d;
    got = ""; stab_err = 0; busy_err = 0; timeout = 1'b0;
    while (got.len() < nbytes) begin
      @(negedge clk);
      cyc++;
      if (cyc > 3000) begin timeout = 1'b1; break; end
      v = sel ? ifb.tx_valid : ifa.tx_valid;
      d = sel ? ifb.tx_data  : ifa.tx_data;
      b = sel ? busy_b : busy_a;
      if (pv && !pr && (!v || d != pd)) stab_err++;
      r = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sel) ifb.tx_ready = r; else ifa.tx_ready = r;
      if (v && r) begin
        got = {got, $sformatf("%c", d)};
        if (got.len() == nbytes && !b) busy_err++;
      end
      pv = v; pd = d; pr = r;
    end
    if (!timeout) begin
      @(negedge clk);
      b = sel ? busy_b : busy_a;
      v = sel ? ifb.tx_valid : ifa.tx_valid;
      if (b || v) busy_err++;
    end
    if (sel) ifb.tx_ready = 1'b1; else ifa.tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (ifa.tx_valid !== 1'b0 || ifa.tx_data !== 8'h00 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_a: valid=%b data=%h busy=%b, required 0/00/0",
               ifa.tx_valid, ifa.tx_data, busy_a);
    end
    n_tests++;
    if (ifb.tx_valid !== 1'b0 || ifb.tx_data !== 8'h00 || busy_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_b: valid=%b data=%h busy=%b, required 0/00/0",
               ifb.tx_valid, ifb.tx_data, busy_b);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    string got; int se, be; bit to;
    ruler_a = case1_bits(); done_a = 1'b1;
    pulse_a();
    n_tests++;
    if (busy_a !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy_rise: busy=%b, required 1", busy_a);
    end
    capture(0, exp_case1.len(), 1'b0, got, se, be, to);
    n_tests++;
    if (to || got != exp_case1) begin
      n_fail++;
      $display("FAIL basic_bytes: got %s, required %s (timeout=%0d)",
               to_hex(got), to_hex(exp_case1), to);
    end
    n_tests++;
    if (be != 0) begin
      n_fail++; $display("FAIL basic_busy_fall: errors=%0d, required 0", be);
    end
  endtask

  task automatic test_not_done();
    string got; int se, be; bit to;
    ruler_a = case1_bits(); done_a = 1'b0;
    pulse_a();
    n_tests++;
    if (ifa.tx_valid !== 1'b0 || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL notdone_cycle1: valid=%b busy=%b, required 0/1", ifa.tx_valid, busy_a);
    end
    @(negedge clk);
    n_tests++;
    if (ifa.tx_valid !== 1'b1 || ifa.tx_data !== 8'h2D) begin
      n_fail++;
      $display("FAIL notdone_dash: valid=%b data=%h, required 1/2d", ifa.tx_valid, ifa.tx_data);
    end
    capture(0, 1, 1'b0, got, se, be, to);
    n_tests++;
    if (to || got != "\n" || be != 0) begin
      n_fail++;
      $display("FAIL notdone_eol: got %s busyerr=%0d, required 0a busyerr=0", to_hex(got), be);
    end
    done_a = 1'b1;
  endtask

  task automatic test_empty_row();
    string got; int se, be; bit to;
    ruler_a = '0; ruler_a[21+5] = 1'b1; done_a = 1'b1;
    pulse_a();
    capture(0, exp_empty.len(), 1'b0, got, se, be, to);
    n_tests++;
    if (to || got != exp_empty || be != 0) begin
      n_fail++;
      $display("FAIL empty_row: got %s busyerr=%0d, required %s", to_hex(got), be, to_hex(exp_empty));
    end
  endtask

  task automatic test_three_digit();
    string got; int se, be; bit to;
    ruler_b = '0; ruler_b[0] = 1'b1; ruler_b[99] = 1'b1;
    ruler_b[100] = 1'b1; ruler_b[140] = 1'b1; done_b = 1'b1;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    capture(1, exp_big.len(), 1'b0, got, se, be, to);
    n_tests++;
    if (to || got != exp_big) begin
      n_fail++;
      $display("FAIL three_digit: got %s, required %s", to_hex(got), to_hex(exp_big));
    end
    n_tests++;
    if (be != 0) begin
      n_fail++; $display("FAIL three_digit_busy: errors=%0d, required 0", be);
    end
  endtask

  task automatic test_stall();
    string got; int se, be; bit to;
    ruler_a = case1_bits(); done_a = 1'b1;
    pulse_a();
    capture(0, exp_case1.len(), 1'b1, got, se, be, to);
    n_tests++;
    if (to || got != exp_case1) begin
      n_fail++;
      $display("FAIL stall_bytes: got %s, required %s", to_hex(got), to_hex(exp_case1));
    end
    n_tests++;
    if (se != 0) begin
      n_fail++; $display("FAIL stall_stable: unstable cycles=%0d, required 0", se);
    end
    n_tests++;
    if (be != 0) begin
      n_fail++; $display("FAIL stall_busy: errors=%0d, required 0", be);
    end
  endtask

  task automatic test_reset_mid();
    string got; int se, be; bit to;
    int cnt = 0; bit hit = 1'b0;
    ruler_a = case1_bits(); done_a = 1'b1; ifa.tx_ready = 1'b1;
    pulse_a();
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      if (ifa.tx_valid) begin
        if (cnt == 2) hit = 1'b1; else cnt++;
      end
    end
    n_tests++;
    if (!hit) begin
      n_fail++; $display("FAIL resetmid_reach: third byte seen=%0d, required 1", hit);
    end
    #2 resetn = 1'b0;
    #1;
    n_tests++;
    if (ifa.tx_valid !== 1'b0 || ifa.tx_data !== 8'h00 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL resetmid_outputs: valid=%b data=%h busy=%b, required 0/00/0",
               ifa.tx_valid, ifa.tx_data, busy_a);
    end
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    pulse_a();
    capture(0, exp_case1.len(), 1'b0, got, se, be, to);
    n_tests++;
    if (to || got != exp_case1 || be != 0) begin
      n_fail++;
      $display("FAIL resetmid_restart: got %s busyerr=%0d, required %s", to_hex(got), be, to_hex(exp_case1));
    end
  endtask

  task automatic test_start_ignored();
    string got; int se, be; bit to;
    int extra = 0;
    ruler_a = case1_bits(); done_a = 1'b1;
    pulse_a();
    fork
      begin
        repeat (6) @(negedge clk);
        ruler_a = '1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
      end
    join_none
    capture(0, exp_case1.len(), 1'b0, got, se, be, to);
    n_tests++;
    if (to || got != exp_case1) begin
      n_fail++;
      $display("FAIL ignore_bytes: got %s, required %s", to_hex(got), to_hex(exp_case1));
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ifa.tx_valid || busy_a) extra++;
    end
    n_tests++;
    if (extra != 0) begin
      n_fail++; $display("FAIL ignore_no_second: active cycles=%0d, required 0", extra);
    end
    ruler_a = case1_bits();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.tx_ready = 1'b1;
    ifb.tx_ready = 1'b1;
    test_reset();
    test_basic();
    test_not_done();
    test_empty_row();
    test_three_digit();
    test_stall();
    test_reset_mid();
    test_start_ignored();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
